// File: rtl/dm_access_ctrl.sv
// Data-memory access controller between the MEM stage and a word-organised
// data memory. It performs byte/half/word loads and stores. Sub-word stores
// are done as read-modify-write. Misaligned or out-of-range accesses return
// AdEL/AdES and never touch memory.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1. req_ready is high only in IDLE. The response is a
// single-cycle resp_valid strobe with no back-pressure. resp_rdata, resp_exc
// and resp_pc are meaningful only while resp_valid is 1, and are 0 otherwise.
module dm_access_ctrl #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc,
  output logic [31:0] resp_pc,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic [2:0]  dbg_state_o
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_ADES = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  addr_lo_q, addr_lo_d;     // byte lane within the word
  logic [31:0] mem_addr_q, mem_addr_d;   // word address; held when idle
  logic [31:0] wdata_q, wdata_d;         // store data, then the merged word
  logic [31:0] pc_q, pc_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  exc_q, exc_d;

  // Opcodes 000..100 are loads; the rest are stores.
  function automatic logic is_load(input logic [2:0] op);
    return (op <= OP_LBU);
  endfunction

  // Alignment by access size, plus the upper address bound for every op.
  function automatic logic is_fault(input logic [2:0] op, input logic [31:0] addr);
    logic misaligned;
    misaligned = 1'b0;
    case (op)
      OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
      default:              misaligned = 1'b0;
    endcase
    return misaligned || (addr >= ADDR_LIMIT);
  endfunction

  // Little-endian lane extraction with sign or zero extension.
  function automatic logic [31:0] load_extract(input logic [2:0]  op,
                                               input logic [1:0]  lo,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LW:   res = word;
      OP_LH:   res = {{16{h[15]}}, h};
      OP_LHU:  res = {16'h0000, h};
      OP_LB:   res = {{24{b[7]}}, b};
      OP_LBU:  res = {24'h000000, b};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Replace only the addressed byte/half of the memory word.
  function automatic logic [31:0] store_merge(input logic [2:0]  op,
                                              input logic [1:0]  lo,
                                              input logic [31:0] word,
                                              input logic [31:0] wd);
    logic [31:0] res;
    res = word;
    if (op == OP_SB) begin
      case (lo)
        2'd0:    res[7:0]   = wd[7:0];
        2'd1:    res[15:8]  = wd[7:0];
        2'd2:    res[23:16] = wd[7:0];
        default: res[31:24] = wd[7:0];
      endcase
    end else if (op == OP_SH) begin
      if (lo[1]) res[31:16] = wd[15:0];
      else       res[15:0]  = wd[15:0];
    end else begin
      res = wd;
    end
    return res;
  endfunction

  // State and captured-request registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      addr_lo_q  <= 2'd0;
      mem_addr_q <= 32'h0;
      wdata_q    <= 32'h0;
      pc_q       <= 32'h0;
      rdata_q    <= 32'h0;
      exc_q      <= EXC_NONE;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_lo_q  <= addr_lo_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      pc_q       <= pc_d;
      rdata_q    <= rdata_d;
      exc_q      <= exc_d;
    end
  end

  // Next-state logic: accept, classify, read, merge, write, respond.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_lo_d  = addr_lo_q;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    pc_d       = pc_q;
    rdata_d    = rdata_q;
    exc_d      = exc_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          addr_lo_d = req_addr[1:0];
          wdata_d   = req_wdata;
          pc_d      = req_pc;
          rdata_d   = 32'h0;
          if (is_fault(req_op, req_addr)) begin
            // Faults skip memory entirely; mem_addr keeps its old value.
            exc_d   = is_load(req_op) ? EXC_ADEL : EXC_ADES;
            state_d = S_RESP;
          end else begin
            exc_d      = EXC_NONE;
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (is_load(req_op))    state_d = S_RD;
            else if (req_op == OP_SW) state_d = S_WR;
            else                    state_d = S_RMW_RD;
          end
        end
      end
      S_RD: begin
        rdata_d = load_extract(op_q, addr_lo_q, mem_rd);
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        wdata_d = store_merge(op_q, addr_lo_q, mem_rd, wdata_q);
        state_d = S_WR;
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode directly from the state register so that reset drops
  // mem_we without waiting for a clock edge.
  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_rdata  = resp_valid ? rdata_q : 32'h0;
  assign resp_exc    = resp_valid ? exc_q : EXC_NONE;
  assign resp_pc     = resp_valid ? pc_q : 32'h0;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = (state_q == S_WR);
  assign mem_wd      = wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: a word memory model, a table of single requests
// with hand-computed results, an asynchronous reset during a write, and a
// back-to-back request stream.
module tb_dm_access_ctrl;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_exc;
    int          exp_lat;
    int          exp_we;
    logic [31:0] exp_wd;
    logic [31:0] exp_waddr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata, resp_pc;
  logic [1:0]  resp_exc;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we;
  logic [2:0]  dbg_state;

  logic [31:0] mem [0:4095];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  logic [31:0] we_wd, we_addr;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc_q[$];
  vec_t        vecs[24];

  dm_access_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_exc   (resp_exc),
    .resp_pc    (resp_pc),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd),
    .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Word memory: combinational read, write on the rising edge
  assign mem_rd = mem[mem_addr[13:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[13:2]] <= mem_wd;

  // Write-enable monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt  <= we_cnt + 1;
      we_wd   <= mem_wd;
      we_addr <= mem_addr;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] pc,
                              input logic [31:0] rd, input logic [1:0] exc,
                              input int lat, input int we,
                              input logic [31:0] wd, input logic [31:0] waddr);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.pc = pc;
    v.exp_rdata = rd; v.exp_exc = exc; v.exp_lat = lat;
    v.exp_we = we; v.exp_wd = wd; v.exp_waddr = waddr;
    return v;
  endfunction

  // Driver: issue one request, then time the response (bounded)
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] pc,
                        output int lat, output logic [31:0] rdata,
                        output logic [1:0] exc, output logic [31:0] rpc,
                        output int wes);
    int w0;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    w0 = we_cnt;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_pc = pc;
    @(posedge clk);
    #1;
    // Scramble the inputs after acceptance; only captured values may matter.
    req_valid = 1'b0; req_op = 3'b111; req_addr = 32'hFFFF_FFFC;
    req_wdata = 32'h5A5A_5A5A; req_pc = 32'hBAD0_BAD0;
    lat = -1; rdata = 32'h0; exc = 2'b11; rpc = 32'h0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i; rdata = resp_rdata; exc = resp_exc; rpc = resp_pc;
        break;
      end
    end
    wes = we_cnt - w0;
  endtask

  // Three requests with req_valid held high throughout
  task automatic b2b();
    logic [2:0]  bop[3];
    logic [31:0] badr[3], bwd[3], bpc[3];
    int          accepted, nresp, last_resp;
    logic        take;
    logic [31:0] e;
    bop[0] = OP_SW; badr[0] = 32'h20; bwd[0] = 32'hDEAD_BEEF; bpc[0] = 32'h0000_0600;
    bop[1] = OP_SB; badr[1] = 32'h21; bwd[1] = 32'h0000_0055; bpc[1] = 32'h0000_0604;
    bop[2] = OP_LW; badr[2] = 32'h20; bwd[2] = 32'h0;         bpc[2] = 32'h0000_0608;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'hDEAD_55EF);
    for (int k = 0; k < 3; k++) exp_pc_q.push_back(bpc[k]);
    accepted = 0; nresp = 0; last_resp = -100;
    @(negedge clk);
    req_valid = 1'b1; req_op = bop[0]; req_addr = badr[0]; req_wdata = bwd[0]; req_pc = bpc[0];
    for (int c = 0; c < 40; c++) begin
      take = 1'b0;
      chk($sformatf("b2b ready c%0d", c), {31'b0, req_ready}, {31'b0, accepted == nresp});
      if (resp_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        chk($sformatf("b2b rdata r%0d", nresp), resp_rdata, e);
        chk($sformatf("b2b exc r%0d", nresp), {30'b0, resp_exc}, 32'h0);
        e = (exp_pc_q.size() > 0) ? exp_pc_q.pop_front() : 32'hXXXX_XXXX;
        chk($sformatf("b2b pc r%0d", nresp), resp_pc, e);
        last_resp = c;
        nresp++;
      end
      if (req_ready && req_valid) begin
        if (accepted > 0) chk($sformatf("b2b accept gap a%0d", accepted), c, last_resp + 1);
        take = 1'b1;
      end
      if (nresp == 3) break;
      @(posedge clk);
      #1;
      if (take) begin
        accepted++;
        if (accepted < 3) begin
          req_op = bop[accepted]; req_addr = badr[accepted];
          req_wdata = bwd[accepted]; req_pc = bpc[accepted];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b responses", nresp, 3);
  endtask

  initial begin
    int          lat, wes;
    logic [31:0] rdata, rpc;
    logic [1:0]  exc;

    // Vector table: mem[0x10] is built up to 0x8034AB78 by the first stores.
    vecs[0]  = mk(OP_SW,  32'h10,   32'h1234_5678, 32'h100, 32'h0,         2'b00, 2, 1, 32'h1234_5678, 32'h10);
    vecs[1]  = mk(OP_SB,  32'h11,   32'h0000_00AB, 32'h104, 32'h0,         2'b00, 3, 1, 32'h1234_AB78, 32'h10);
    vecs[2]  = mk(OP_SB,  32'h13,   32'hFFFF_FF80, 32'h108, 32'h0,         2'b00, 3, 1, 32'h8034_AB78, 32'h10);
    vecs[3]  = mk(OP_LB,  32'h13,   32'h0,         32'h10C, 32'hFFFF_FF80, 2'b00, 2, 0, 32'h0, 32'h0);
    vecs[4]  = mk(OP_LBU, 32'h13,   32'h0,         32'h110, 32'h0000_0080, 2'b00, 2, 0, 32'h0, 32'h0);
    vecs[5]  = mk(OP_LH,  32'h12,   32'h0,         32'h114, 32'hFFFF_8034, 2'b00, 2, 0, 32'h0, 32'h0);
    vecs[6]  = mk(OP_LHU, 32'h10,   32'h0,         32'h118, 32'h0000_AB78, 2'b00, 2, 0, 32'h0, 32'h0);
    vecs[7]  = mk(OP_LW,  32'h10,   32'h0,         32'h11C, 32'h8034_AB78, 2'b00, 2, 0, 32'h0, 32'h0);
    vecs[8]  = mk(OP_LB,  32'h11,   32'h0,         32'h120, 32'hFFFF_FFAB, 2'b00, 2, 0, 32'h0, 32'h0);
    vecs[9]  = mk(OP_LBU, 32'h10,   32'h0,         32'h124, 32'h0000_0078, 2'b00, 2, 0, 32'h0, 32'h0);
    vecs[10] = mk(OP_SH,  32'h12,   32'h1234_CAFE, 32'h128, 32'h0,         2'b00, 3, 1, 32'hCAFE_AB78, 32'h10);
    vecs[11] = mk(OP_LH,  32'h12,   32'h0,         32'h12C, 32'hFFFF_CAFE, 2'b00, 2, 0, 32'h0, 32'h0);
    vecs[12] = mk(OP_LH,  32'h10,   32'h0,         32'h130, 32'hFFFF_AB78, 2'b00, 2, 0, 32'h0, 32'h0);
    vecs[13] = mk(OP_LW,  32'h02,   32'h0,         32'h134, 32'h0,         2'b01, 1, 0, 32'h0, 32'h0);
    vecs[14] = mk(OP_SH,  32'h05,   32'hFFFF_FFFF, 32'h138, 32'h0,         2'b10, 1, 0, 32'h0, 32'h0);
    vecs[15] = mk(OP_SW,  32'h3000, 32'hFFFF_FFFF, 32'h13C, 32'h0,         2'b10, 1, 0, 32'h0, 32'h0);
    vecs[16] = mk(OP_LB,  32'h3000, 32'h0,         32'h140, 32'h0,         2'b01, 1, 0, 32'h0, 32'h0);
    vecs[17] = mk(OP_LW,  32'h2FFC, 32'h0,         32'h144, 32'h7F00_0001, 2'b00, 2, 0, 32'h0, 32'h0);
    vecs[18] = mk(OP_SB,  32'h2FFF, 32'h0000_00EE, 32'h148, 32'h0,         2'b00, 3, 1, 32'hEE00_0001, 32'h2FFC);
    vecs[19] = mk(OP_LHU, 32'h2FFE, 32'h0,         32'h14C, 32'h0000_EE00, 2'b00, 2, 0, 32'h0, 32'h0);
    vecs[20] = mk(OP_LH,  32'h01,   32'h0,         32'h150, 32'h0,         2'b01, 1, 0, 32'h0, 32'h0);
    vecs[21] = mk(OP_LB,  32'h12,   32'h0,         32'h154, 32'hFFFF_FFFE, 2'b00, 2, 0, 32'h0, 32'h0);
    vecs[22] = mk(OP_SH,  32'h11,   32'h0000_1111, 32'h158, 32'h0,         2'b10, 1, 0, 32'h0, 32'h0);
    vecs[23] = mk(OP_SW,  32'h12,   32'h2222_2222, 32'h15C, 32'h0,         2'b10, 1, 0, 32'h0, 32'h0);

    // Clock/reset
    reset = 1'b1; req_valid = 1'b0; req_op = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
    for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
    mem[12'hBFF] <= 32'h7F00_0001;
    mem[12'h005] <= 32'h1122_3344;
    #2;
    chk("reset req_ready",  {31'b0, req_ready},  32'h1);
    chk("reset resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("reset mem_we",     {31'b0, mem_we},     32'h0);
    chk("reset mem_addr",   mem_addr,            32'h0);
    chk("reset mem_wd",     mem_wd,              32'h0);
    chk("reset resp_rdata", resp_rdata,          32'h0);
    chk("reset resp_exc",   {30'b0, resp_exc},   32'h0);
    chk("reset resp_pc",    resp_pc,             32'h0);
    chk("reset state",      {29'b0, dbg_state},  32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Table-driven single requests
    for (int i = 0; i < 24; i++) begin
      do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].pc, lat, rdata, exc, rpc, wes);
      chk($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d exc", i), {30'b0, exc}, {30'b0, vecs[i].exp_exc});
      chk($sformatf("v%0d pc", i), rpc, vecs[i].pc);
      chk($sformatf("v%0d we cycles", i), wes, vecs[i].exp_we);
      if (vecs[i].exp_we > 0) begin
        chk($sformatf("v%0d mem_wd", i), we_wd, vecs[i].exp_wd);
        chk($sformatf("v%0d mem_addr", i), we_addr, vecs[i].exp_waddr);
      end
      @(negedge clk);
      chk($sformatf("v%0d strobe drop", i), {31'b0, resp_valid}, 32'h0);
      chk($sformatf("v%0d ready back", i), {31'b0, req_ready}, 32'h1);
    end

    // Reset asserted while an SH sits in WR
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SH; req_addr = 32'h14;
    req_wdata = 32'h0000_7777; req_pc = 32'h500;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst we before", {31'b0, mem_we}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst we async drop", {31'b0, mem_we}, 32'h0);
    chk("rst no resp",       {31'b0, resp_valid}, 32'h0);
    @(negedge clk);
    chk("rst no resp held",  {31'b0, resp_valid}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst no resp after", {31'b0, resp_valid}, 32'h0);
    chk("rst ready after",   {31'b0, req_ready}, 32'h1);
    chk("rst mem untouched", mem[12'h005], 32'h1122_3344);
    do_req(OP_LW, 32'h14, 32'h0, 32'h504, lat, rdata, exc, rpc, wes);
    chk("post-rst lw latency", lat, 2);
    chk("post-rst lw rdata",   rdata, 32'h1122_3344);
    chk("post-rst lw exc",     {30'b0, exc}, 32'h0);
    chk("post-rst lw pc",      rpc, 32'h504);

    // Back-to-back stream
    b2b();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
